// File: rtl/skinny_masked_pkg.sv
// Shared constants and types for the first-order DOM-masked SKINNY S-box datapath.
// A share2_t carries one masked bit: [0] is share 0, [1] is share 1.
package skinny_masked_pkg;

    localparam int SBOX8_LAT      = 8;
    localparam int GATE_LAT       = 2;
    localparam int GATES_PER_SBOX = 8;

    // Output bit b of an S-box is taken from aligned gate node OUT_SRC[b]
    localparam int OUT_SRC [8] = '{7, 5, 2, 4, 6, 1, 0, 3};

    typedef logic [1:0] share2_t;

endpackage

// File: rtl/dom1_nor_xor_gate.sv
// Two-share DOM gate computing NOR(x,y)^z with a 2-cycle registered pipeline.
// Cross-share AND terms are refreshed with r and registered before recombination.
module dom1_nor_xor_gate (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic [1:0] z,
    input  logic       r,
    output logic [1:0] f
);

    (* keep = "true" *) logic g0_q, g1_q, t0_q, t1_q, f0_q, f1_q;
    logic g0_d, g1_d, t0_d, t1_d, f0_d, f1_d;

    always_comb begin
        g0_d = g0_q;
        g1_d = g1_q;
        t0_d = t0_q;
        t1_d = t1_q;
        f0_d = f0_q;
        f1_d = f1_q;
        if (en) begin
            g0_d = (x[0] & y[0]) ^ z[0];
            g1_d = (~x[1] & ~y[1]) ^ z[1];
            t0_d = (~y[1] & x[0]) ^ r;
            t1_d = (~x[1] & y[0]) ^ r;
            f0_d = t0_q ^ g0_q;
            f1_d = t1_q ^ g1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g0_q <= 1'b0;
            g1_q <= 1'b0;
            t0_q <= 1'b0;
            t1_q <= 1'b0;
            f0_q <= 1'b0;
            f1_q <= 1'b0;
        end else begin
            g0_q <= g0_d;
            g1_q <= g1_d;
            t0_q <= t0_d;
            t1_q <= t1_d;
            f0_q <= f0_d;
            f1_q <= f1_d;
        end
    end

    assign f = {f1_q, f0_q};

endmodule

// File: rtl/skinny_sbox8_dom1_pipelined_array.sv
// NSBOX parallel two-share SKINNY 8-bit S-boxes, 8-cycle pipeline with valid/ready.
// Every register advances only when the output slot is free or being consumed.
module skinny_sbox8_dom1_pipelined_array
    import skinny_masked_pkg::*;
#(
    parameter  int NSBOX = 16,
    localparam int W     = 8 * NSBOX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] si0,
    input  logic [W-1:0] si1,
    input  logic [W-1:0] r,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] bo0,
    output logic [W-1:0] bo1,
    output logic         out_valid,
    input  logic         out_ready
);

    // Balancing delay chains, laid end to end in one shift vector per S-box
    localparam int CH_B5 = 0, CH_B3 = 1, CH_B1 = 2, CH_B7 = 3, CH_B2 = 4, CH_A0 = 5;
    localparam int CH_A1 = 6, CH_A2 = 7, CH_A3 = 8, CH_A4 = 9, CH_A5 = 10, CH_A6 = 11;
    localparam int NCH = 12;
    localparam int CH_DEPTH [NCH] = '{GATE_LAT, 2*GATE_LAT, GATE_LAT, 2*GATE_LAT,
                                      3*GATE_LAT, 3*GATE_LAT, 3*GATE_LAT, 3*GATE_LAT,
                                      2*GATE_LAT, 2*GATE_LAT, GATE_LAT, GATE_LAT};

    function automatic int ch_base(input int ch);
        int s;
        s = 0;
        for (int c = 0; c < ch; c++) s += CH_DEPTH[c];
        return s;
    endfunction

    function automatic int tap(input int ch, input int depth);
        return ch_base(ch) + depth - 1;
    endfunction

    localparam int NSR   = ch_base(NCH);
    localparam int B5_D2 = tap(CH_B5, GATE_LAT);
    localparam int B3_D2 = tap(CH_B3, GATE_LAT);
    localparam int B3_D4 = tap(CH_B3, 2*GATE_LAT);
    localparam int B1_D2 = tap(CH_B1, GATE_LAT);
    localparam int B7_D4 = tap(CH_B7, 2*GATE_LAT);
    localparam int B2_D6 = tap(CH_B2, 3*GATE_LAT);
    localparam int A0_D2 = tap(CH_A0, GATE_LAT);
    localparam int A0_D6 = tap(CH_A0, 3*GATE_LAT);
    localparam int A1_D6 = tap(CH_A1, 3*GATE_LAT);
    localparam int A2_D2 = tap(CH_A2, GATE_LAT);
    localparam int A2_D6 = tap(CH_A2, 3*GATE_LAT);
    localparam int A3_D4 = tap(CH_A3, 2*GATE_LAT);
    localparam int A4_D2 = tap(CH_A4, GATE_LAT);
    localparam int A4_D4 = tap(CH_A4, 2*GATE_LAT);
    localparam int A5_D2 = tap(CH_A5, GATE_LAT);
    localparam int A6_D2 = tap(CH_A6, GATE_LAT);

    logic adv;
    (* keep = "true" *) logic [SBOX8_LAT-1:0] vld_q;
    logic [SBOX8_LAT-1:0] vld_d;

    assign out_valid = vld_q[SBOX8_LAT-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    always_comb begin
        vld_d = vld_q;
        if (adv) vld_d = {vld_q[SBOX8_LAT-2:0], in_valid};
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    for (genvar gi = 0; gi < NSBOX; gi++) begin : g_sbox
        share2_t [7:0]                b;
        share2_t [GATES_PER_SBOX-1:0] a, gx, gy, gz;
        share2_t [7:0]                o;
        share2_t [NCH-1:0]            sr_src;
        share2_t [NSR-1:0]            sr_in;
        (* keep = "true" *) share2_t [NSR-1:0] sr_q;
        share2_t [NSR-1:0]            sr_d;

        for (genvar bi = 0; bi < 8; bi++) begin : g_bit
            assign b[bi]          = {si1[8*gi+bi], si0[8*gi+bi]};
            assign bo0[8*gi+bi]   = o[OUT_SRC[bi]][0];
            assign bo1[8*gi+bi]   = o[OUT_SRC[bi]][1];
        end

        assign sr_src = {a[6], a[5], a[4], a[3], a[2], a[1], a[0],
                         b[2], b[7], b[1], b[3], b[5]};

        for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
            assign sr_in[ch_base(gc)] = sr_src[gc];
            for (genvar gj = 1; gj < CH_DEPTH[gc]; gj++) begin : g_stage
                assign sr_in[ch_base(gc)+gj] = sr_q[ch_base(gc)+gj-1];
            end
        end

        always_comb begin
            sr_d = sr_q;
            if (adv) sr_d = sr_in;
        end

        always_ff @(posedge clk) begin
            if (rst) sr_q <= '0;
            else     sr_q <= sr_d;
        end

        // Gate k operands, each aligned to the cycle its level starts
        assign gx = {sr_q[A4_D2], a[3],        sr_q[A2_D2], a[1],
                     a[0],        b[2],        b[3],        b[7]};
        assign gy = {a[5],        sr_q[A0_D2], a[3],        sr_q[B3_D2],
                     a[1],        b[1],        b[2],        b[6]};
        assign gz = {sr_q[B2_D6], sr_q[B3_D4], sr_q[B7_D4], sr_q[B1_D2],
                     sr_q[B5_D2], b[6],        b[0],        b[4]};

        assign o = {a[7], sr_q[A6_D2], sr_q[A5_D2], sr_q[A4_D4],
                    sr_q[A3_D4], sr_q[A2_D6], sr_q[A1_D6], sr_q[A0_D6]};

        for (genvar gk = 0; gk < GATES_PER_SBOX; gk++) begin : g_gate
            dom1_nor_xor_gate u_gate (
                .clk (clk),
                .rst (rst),
                .en  (adv),
                .x   (gx[gk]),
                .y   (gy[gk]),
                .z   (gz[gk]),
                .r   (r[8*gi+gk]),
                .f   (a[gk])
            );
        end
    end

endmodule

// File: tb/tb_skinny_sbox8_dom1_pipelined_array.sv
// Scoreboard bench: driver pushes expected unmasked results, monitor ages and checks them.
module tb_skinny_sbox8_dom1_pipelined_array;

    localparam int NSBOX = 16;
    localparam int W     = 8 * NSBOX;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] si0 = '0;
    logic [W-1:0] si1 = '0;
    logic [W-1:0] r   = '0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] bo0, bo1;
    logic         out_valid;
    logic         out_ready = 1'b1;

    always #5 clk = ~clk;

    skinny_sbox8_dom1_pipelined_array #(.NSBOX(NSBOX)) dut (
        .clk       (clk),
        .rst       (rst),
        .si0       (si0),
        .si1       (si1),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bo0       (bo0),
        .bo1       (bo1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        int           age;
        logic [W-1:0] exp;
        bit           indep;
    } item_t;

    item_t        sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] cur_exp = '0;
    bit           cur_indep = 0;
    bit           last_accept = 0;
    int           ready_mode = 1;

    function automatic logic nx(input logic x, input logic y, input logic z);
        return ~(x | y) ^ z;
    endfunction

    // Unmasked S8 as a plain NOR/XOR network
    function automatic logic [7:0] sbox8(input logic [7:0] v);
        logic a0, a1, a2, a3, a4, a5, a6, a7;
        a0 = nx(v[7], v[6], v[4]);
        a1 = nx(v[3], v[2], v[0]);
        a2 = nx(v[2], v[1], v[6]);
        a3 = nx(a0, a1, v[5]);
        a4 = nx(a1, v[3], v[1]);
        a5 = nx(a2, a3, v[7]);
        a6 = nx(a3, a0, v[3]);
        a7 = nx(a4, a5, v[2]);
        return {a3, a0, a1, a6, a4, a2, a5, a7};
    endfunction

    function automatic logic [W-1:0] sbox_vec(input logic [W-1:0] p);
        logic [W-1:0] v;
        for (int i = 0; i < NSBOX; i++) v[8*i +: 8] = sbox8(p[8*i +: 8]);
        return v;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic chk_ne(input string name, input logic [W-1:0] act, input logic [W-1:0] forbid);
        checks++;
        if (act === forbid) begin
            errors++;
            $display("FAIL %s: share %h equals unmasked result %h", name, act, forbid);
        end
    endtask

    // Fresh randomness and consumer back-pressure every cycle
    initial begin
        forever begin
            @(negedge clk);
            r = rand_w();
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: sample just before each rising edge, then age the model
    initial begin
        logic [W-1:0] prev_bo0, prev_bo1;
        bit prev_hold, expect_zero, head;
        prev_bo0 = '0;
        prev_bo1 = '0;
        prev_hold = 0;
        expect_zero = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #4;
            head = (sb.size() > 0) && (sb[0].age == 8);
            chk("out_valid", W'(out_valid), W'(head));
            chk("in_ready", W'(in_ready), W'(!head || out_ready));
            if (head) begin
                chk("data", bo0 ^ bo1, sb[0].exp);
                if (sb[0].indep) begin
                    chk_ne("indep_bo0", bo0, sb[0].exp);
                    chk_ne("indep_bo1", bo1, sb[0].exp);
                end
                $display("out txn: bo0=%h bo1=%h unmasked=%h", bo0, bo1, bo0 ^ bo1);
            end
            if (expect_zero) begin
                chk("rst_bo0", bo0, '0);
                chk("rst_bo1", bo1, '0);
            end
            if (prev_hold) begin
                chk("hold_bo0", bo0, prev_bo0);
                chk("hold_bo1", bo1, prev_bo1);
            end
            prev_hold   = head && !out_ready && !rst;
            prev_bo0    = bo0;
            prev_bo1    = bo1;
            expect_zero = rst;
            last_accept = 0;
            if (rst) begin
                sb.delete();
            end else if (!head || out_ready) begin
                if (head) void'(sb.pop_front());
                foreach (sb[i]) sb[i].age++;
                if (in_valid) begin
                    sb.push_back('{age: 1, exp: cur_exp, indep: cur_indep});
                    last_accept = 1;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] plain, input logic [W-1:0] mask,
                        input logic [W-1:0] exp, input bit indep);
        int tries;
        tries = 0;
        cur_exp   = exp;
        cur_indep = indep;
        do begin
            @(negedge clk);
            in_valid = 1'b1;
            si0 = mask;
            si1 = plain ^ mask;
            @(posedge clk);
            #1;
            tries++;
        end while (!last_accept && tries < 200);
        in_valid = 1'b0;
        if (!last_accept) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual not accepted required accepted within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            si0 = rand_w();
            si1 = rand_w();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: actual %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        logic [W-1:0] p, e, fixed;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Zero shares, then equal 0x5A shares: both unmask to 0x00 -> 0x65
        ready_mode = 1;
        send('0, '0, {NSBOX{8'h65}}, 0);
        send('0, {NSBOX{8'h5A}}, {NSBOX{8'h65}}, 0);
        for (int i = 0; i < NSBOX; i++) begin
            p[8*i +: 8] = (i % 2 == 0) ? 8'h01 : 8'hFF;
            e[8*i +: 8] = (i % 2 == 0) ? 8'h4C : 8'hFF;
        end
        send(p, rand_w(), e, 0);
        drain();

        // All 256 byte values with random masks and random back-pressure
        ready_mode = 2;
        for (int t = 0; t < 256 / NSBOX; t++) begin
            for (int i = 0; i < NSBOX; i++) p[8*i +: 8] = 8'(NSBOX * t + i);
            send(p, rand_w(), sbox_vec(p), 0);
        end
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            p = rand_w();
            send(p, rand_w(), sbox_vec(p), 0);
        end
        drain();

        // Alternating valid pattern
        ready_mode = 1;
        for (int t = 0; t < 10; t++) begin
            p = rand_w();
            send(p, rand_w(), sbox_vec(p), 0);
            idle(1);
        end
        drain();

        // Fill the pipe, stall 5 cycles, then release
        ready_mode = 0;
        for (int t = 0; t < 8; t++) begin
            p = rand_w();
            send(p, rand_w(), sbox_vec(p), 0);
        end
        idle(5);
        ready_mode = 1;
        drain();

        // Reset with 6 transactions in flight
        for (int t = 0; t < 6; t++) begin
            p = rand_w();
            send(p, rand_w(), sbox_vec(p), 0);
        end
        do_reset();
        for (int t = 0; t < 4; t++) begin
            p = rand_w();
            send(p, rand_w(), sbox_vec(p), 0);
        end
        drain();

        // Fixed unmasked input, varying masks and randomness
        ready_mode = 2;
        fixed = rand_w();
        for (int t = 0; t < 20; t++) send(fixed, rand_w(), sbox_vec(fixed), 1);
        drain();

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
